// File: rtl/uart_rom_loader.sv
// UART 8N1 program loader: receives a framed image and writes it word-by-word into the
// instruction ROM while holding the core in reset.
module uart_rom_loader #(
  parameter int                CLK_FREQ  = 50_000_000,
  parameter int                BAUD      = 115200,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx_i,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [31:0]       rom_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [7:0]       HEADER    = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  typedef enum logic [2:0] {
    FR_IDLE,
    FR_CNT_L,
    FR_CNT_H,
    FR_DATA,
    FR_CSUM,
    FR_DONE
  } frameState_t;

  logic             rxMeta_q;
  logic             rxSync_q;
  logic             rxPrev_q;
  rxState_t         rxState_q;
  logic [CNT_W-1:0] clkCnt_q;
  logic [2:0]       bitCnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       rxByte_q;
  logic             byteValid_q;
  logic             frameErr_q;

  frameState_t      frState_q;
  logic [15:0]      count_q;
  logic [15:0]      wordIdx_q;
  logic [1:0]       byteIdx_q;
  logic [7:0]       sum_q;
  logic [23:0]      word_q;
  logic             romWe_q;
  logic [ADDR_W-1:0] romAddr_q;
  logic [31:0]      romData_q;
  logic             hold_q;
  logic             done_q;
  logic             err_q;

  logic [ADDR_W-1:0] wordAddr_d;
  logic [15:0]       lastWord_d;
  logic [15:0]       countFull_d;

  assign wordAddr_d  = BASE_ADDR + ADDR_W'({wordIdx_q, 2'b00});
  assign lastWord_d  = count_q - 16'd1;
  assign countFull_d = {rxByte_q, count_q[7:0]};

  // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= uart_rx_i;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // Bit-level receiver: start bit re-checked at half a bit so short glitches are dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxState_q   <= RX_IDLE;
      clkCnt_q    <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      rxByte_q    <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (rxPrev_q && !rxSync_q) begin
            rxState_q <= RX_START;
            clkCnt_q  <= '0;
          end
        end
        RX_START: begin
          if (clkCnt_q == HALF_LAST) begin
            clkCnt_q  <= '0;
            bitCnt_q  <= '0;
            rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            clkCnt_q <= clkCnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (clkCnt_q == BIT_LAST) begin
            clkCnt_q <= '0;
            shift_q  <= {rxSync_q, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 3'd7) begin
              rxState_q <= RX_STOP;
            end
          end else begin
            clkCnt_q <= clkCnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (clkCnt_q == BIT_LAST) begin
            clkCnt_q  <= '0;
            rxState_q <= RX_IDLE;
            if (rxSync_q) begin
              byteValid_q <= 1'b1;
              rxByte_q    <= shift_q;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            clkCnt_q <= clkCnt_q + 1'b1;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  // Frame parser: header, 16-bit word count, little-endian words, then an 8-bit data checksum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frState_q <= FR_IDLE;
      count_q   <= '0;
      wordIdx_q <= '0;
      byteIdx_q <= '0;
      sum_q     <= '0;
      word_q    <= '0;
      romWe_q   <= 1'b0;
      romAddr_q <= '0;
      romData_q <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      romWe_q <= 1'b0;
      done_q  <= 1'b0;
      if (frameErr_q) begin
        err_q     <= 1'b1;
        hold_q    <= 1'b0;
        frState_q <= FR_IDLE;
      end else begin
        case (frState_q)
          FR_IDLE: begin
            if (byteValid_q && rxByte_q == HEADER) begin
              err_q     <= 1'b0;
              hold_q    <= 1'b1;
              frState_q <= FR_CNT_L;
            end
          end
          FR_CNT_L: begin
            if (byteValid_q) begin
              count_q[7:0] <= rxByte_q;
              frState_q    <= FR_CNT_H;
            end
          end
          FR_CNT_H: begin
            if (byteValid_q) begin
              count_q[15:8] <= rxByte_q;
              byteIdx_q     <= '0;
              wordIdx_q     <= '0;
              sum_q         <= '0;
              frState_q     <= (countFull_d == 16'd0) ? FR_CSUM : FR_DATA;
            end
          end
          FR_DATA: begin
            if (byteValid_q) begin
              sum_q <= sum_q + rxByte_q;
              case (byteIdx_q)
                2'd0: word_q[7:0]   <= rxByte_q;
                2'd1: word_q[15:8]  <= rxByte_q;
                2'd2: word_q[23:16] <= rxByte_q;
                default: begin
                  romWe_q   <= 1'b1;
                  romData_q <= {rxByte_q, word_q};
                  romAddr_q <= wordAddr_d;
                  wordIdx_q <= wordIdx_q + 16'd1;
                  if (wordIdx_q == lastWord_d) begin
                    frState_q <= FR_CSUM;
                  end
                end
              endcase
              byteIdx_q <= byteIdx_q + 2'd1;
            end
          end
          FR_CSUM: begin
            if (byteValid_q) begin
              if (rxByte_q == sum_q) begin
                frState_q <= FR_DONE;
              end else begin
                err_q     <= 1'b1;
                hold_q    <= 1'b0;
                frState_q <= FR_IDLE;
              end
            end
          end
          FR_DONE: begin
            done_q    <= 1'b1;
            hold_q    <= 1'b0;
            frState_q <= FR_IDLE;
          end
          default: frState_q <= FR_IDLE;
        endcase
      end
    end
  end

  assign rom_we_o   = romWe_q;
  assign rom_addr_o = romAddr_q;
  assign rom_data_o = romData_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader: table of complete frames plus hand-written
// sequences for framing errors, glitches, junk bytes and mid-load reset.
module tb_uart_rom_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        uart_rx_i;
  logic        rom_we_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrAddr [64];
  logic [31:0] wrData [64];
  int          wrCount   = 0;
  int          doneCount = 0;

  typedef struct {
    logic [7:0]  bytes [12];
    int          nBytes;
    int          expWrites;
    logic [31:0] expData [2];
    int          expDone;
    logic        expErr;
  } vec_t;

  vec_t vecs [4];

  uart_rom_loader #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .ADDR_W   (32),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .uart_rx_i (uart_rx_i),
    .rom_we_o  (rom_we_o),
    .rom_addr_o(rom_addr_o),
    .rom_data_o(rom_data_o),
    .cpu_hold_o(cpu_hold_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // Record every write strobe and every cycle done_o is high.
  always @(negedge clk) begin
    if (rom_we_o) begin
      wrAddr[wrCount % 64] = rom_addr_o;
      wrData[wrCount % 64] = rom_data_o;
      wrCount = wrCount + 1;
    end
    if (done_o) begin
      doneCount = doneCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called and returns on a falling clock edge; 10 clocks per bit.
  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    uart_rx_i = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (10) @(negedge clk);
    end
    uart_rx_i = stopBit;
    repeat (10) @(negedge clk);
    uart_rx_i = 1'b1;
  endtask

  task automatic applyStimulus(input int idx, input int first, input int last);
    for (int i = first; i < last; i++) begin
      sendByte(vecs[idx].bytes[i], 1'b1);
    end
  endtask

  task automatic checkIdleOutputs(input string tag, input logic expErr);
    checkOutput({tag, " cpu_hold_o"}, {31'b0, cpu_hold_o}, 32'd0);
    checkOutput({tag, " err_o"}, {31'b0, err_o}, {31'b0, expErr});
  endtask

  initial begin
    int wrBase;
    int doneBase;

    vecs[0].bytes     = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[0].nBytes    = 8;
    vecs[0].expWrites = 1;
    vecs[0].expData   = '{32'h12345678, 32'h0};
    vecs[0].expDone   = 1;
    vecs[0].expErr    = 1'b0;

    vecs[1].bytes     = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    vecs[1].nBytes    = 12;
    vecs[1].expWrites = 2;
    vecs[1].expData   = '{32'h04030201, 32'h08070605};
    vecs[1].expDone   = 1;
    vecs[1].expErr    = 1'b0;

    vecs[2].bytes     = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].nBytes    = 8;
    vecs[2].expWrites = 1;
    vecs[2].expData   = '{32'h12345678, 32'h0};
    vecs[2].expDone   = 0;
    vecs[2].expErr    = 1'b1;

    vecs[3].bytes     = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].nBytes    = 4;
    vecs[3].expWrites = 0;
    vecs[3].expData   = '{32'h0, 32'h0};
    vecs[3].expDone   = 1;
    vecs[3].expErr    = 1'b0;

    rstn      = 1'b0;
    uart_rx_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset rom_we_o", {31'b0, rom_we_o}, 32'd0);
    checkOutput("reset rom_addr_o", rom_addr_o, 32'd0);
    checkOutput("reset rom_data_o", rom_data_o, 32'd0);
    checkOutput("reset done_o", {31'b0, done_o}, 32'd0);
    checkIdleOutputs("reset", 1'b0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      wrBase   = wrCount;
      doneBase = doneCount;
      applyStimulus(v, 0, 3);
      checkOutput($sformatf("vec%0d hold after header", v), {31'b0, cpu_hold_o}, 32'd1);
      checkOutput($sformatf("vec%0d err cleared by header", v), {31'b0, err_o}, 32'd0);
      applyStimulus(v, 3, vecs[v].nBytes);
      repeat (30) @(negedge clk);
      checkOutput($sformatf("vec%0d write count", v), wrCount - wrBase, vecs[v].expWrites);
      for (int w = 0; w < vecs[v].expWrites; w++) begin
        checkOutput($sformatf("vec%0d addr%0d", v, w), wrAddr[(wrBase + w) % 64], 32'(4 * w));
        checkOutput($sformatf("vec%0d data%0d", v, w), wrData[(wrBase + w) % 64], vecs[v].expData[w]);
      end
      checkOutput($sformatf("vec%0d done cycles", v), doneCount - doneBase, vecs[v].expDone);
      checkIdleOutputs($sformatf("vec%0d", v), vecs[v].expErr);
    end

    // Short low glitch and a junk byte while idle must change nothing.
    wrBase   = wrCount;
    doneBase = doneCount;
    uart_rx_i = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (40) @(negedge clk);
    checkIdleOutputs("glitch", 1'b0);
    sendByte(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    checkIdleOutputs("junk byte", 1'b0);
    checkOutput("glitch/junk writes", wrCount - wrBase, 0);

    // Stop bit forced low on the third data byte aborts the load.
    wrBase   = wrCount;
    doneBase = doneCount;
    sendByte(8'hA5, 1'b1);
    sendByte(8'h01, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h78, 1'b1);
    sendByte(8'h56, 1'b1);
    sendByte(8'h34, 1'b0);
    repeat (30) @(negedge clk);
    checkIdleOutputs("framing", 1'b1);
    checkOutput("framing writes", wrCount - wrBase, 0);
    checkOutput("framing done", doneCount - doneBase, 0);

    // Reset in the middle of the second word, then reload from the base address.
    wrBase = wrCount;
    sendByte(8'hA5, 1'b1);
    sendByte(8'h02, 1'b1);
    sendByte(8'h00, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      sendByte(8'(i), 1'b1);
    end
    checkOutput("midload first write data", wrData[wrBase % 64], 32'h04030201);
    uart_rx_i = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("midload hold before reset", {31'b0, cpu_hold_o}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async reset rom_data_o", rom_data_o, 32'd0);
    checkOutput("async reset rom_addr_o", rom_addr_o, 32'd0);
    checkOutput("async reset rom_we_o", {31'b0, rom_we_o}, 32'd0);
    checkIdleOutputs("async reset", 1'b0);
    uart_rx_i = 1'b1;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    wrBase   = wrCount;
    doneBase = doneCount;
    sendByte(8'hA5, 1'b1);
    sendByte(8'h01, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'hEF, 1'b1);
    sendByte(8'hBE, 1'b1);
    sendByte(8'hAD, 1'b1);
    sendByte(8'hDE, 1'b1);
    sendByte(8'h38, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("reload write count", wrCount - wrBase, 1);
    checkOutput("reload addr", wrAddr[wrBase % 64], 32'h0);
    checkOutput("reload data", wrData[wrBase % 64], 32'hDEADBEEF);
    checkOutput("reload done", doneCount - doneBase, 1);
    checkIdleOutputs("reload", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
